// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the PRBS9 receive checker. The bit mapping and the
// PRBS polynomial are shared with the transmit side (tx_top), so both ends of
// a loopback agree on the polarity of a bit and on the sequence itself.
//   - PRBS9 polynomial x^9 + x^5 + 1, feedback taps at register bits 8 and 4
//   - Reset seed 9'h1FF
//   - FSM state encoding (SEARCH / LOCKED)
//   - Bit mapping: bit 0 <-> positive sample, bit 1 <-> negative sample;
//     the I bit is the first bit of a symbol, the Q bit is the second
// -----------------------------------------------------------------------------
package rx_pkg;

  localparam int         PRBS_TAP_HI = 8;
  localparam int         PRBS_TAP_LO = 4;
  localparam logic [8:0] PRBS_SEED   = 9'h1FF;

  localparam logic ST_SEARCH = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    STATE_SEARCH = ST_SEARCH,
    STATE_LOCKED = ST_LOCKED
  } state_e;

  // Hard decision on a two's complement sample: a negative sample carries
  // bit 1, a positive or zero sample carries bit 0. That is exactly the sign bit.
  function automatic logic slice_bit(input logic sample_msb);
    return sample_msb;
  endfunction

  // Number of set bits in a two-bit error vector.
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/prbs9_step2.sv
// -----------------------------------------------------------------------------
// prbs9_step2
// Purely combinational two-bit advance of the PRBS9 register. The I bit is
// processed first, then the Q bit against the once-shifted register.
// Ports:
//   lfsr_in  [8:0]  current register contents
//   mode            ST_SEARCH: shift in the received bit (self-seeding)
//                   ST_LOCKED: shift in the prediction (free-running)
//   b_i, b_q        received hard bits of the symbol
//   lfsr_out [8:0]  register after both bits
//   p_i, p_q        predicted bits for I and Q
// -----------------------------------------------------------------------------
module prbs9_step2
  import rx_pkg::*;
(
  input  logic [8:0] lfsr_in,
  input  logic       mode,
  input  logic       b_i,
  input  logic       b_q,
  output logic [8:0] lfsr_out,
  output logic       p_i,
  output logic       p_q
);

  logic [8:0] w_lfsr_mid;

  assign p_i        = lfsr_in[PRBS_TAP_HI] ^ lfsr_in[PRBS_TAP_LO];
  assign w_lfsr_mid = {lfsr_in[7:0], (mode == ST_LOCKED) ? p_i : b_i};
  assign p_q        = w_lfsr_mid[PRBS_TAP_HI] ^ w_lfsr_mid[PRBS_TAP_LO];
  assign lfsr_out   = {w_lfsr_mid[7:0], (mode == ST_LOCKED) ? p_q : b_q};

endmodule

// File: rtl/rx_prbs_checker.sv
// -----------------------------------------------------------------------------
// rx_prbs_checker
// Receive-side PRBS9 checker. Slices each I/Q sample to one hard bit, keeps a
// local PRBS9 in step with the incoming stream and counts bit errors once the
// stream is locked.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          sample valid, one I/Q symbol per cycle while high
//   rx_i, rx_q  signed samples (DATA_WIDTH)
//   clr_cnt     synchronous clear of bit_cnt/err_cnt (lock state untouched)
//   locked      1 while in LOCKED
//   err_valid   one-cycle pulse, err_bits valid
//   err_bits    per-symbol mismatch flags {I,Q}
//   bit_cnt     bits checked while locked (saturating)
//   err_cnt     bit errors seen while locked (saturating)
// Pipeline: stage 1 slices the samples, stage 2 predicts, compares, advances
// the LFSR and runs the lock FSM, so a sample appears on err_bits two edges
// after it is presented.
// -----------------------------------------------------------------------------
module rx_prbs_checker
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_SYMS  = 16,
  parameter int WIN_SYMS   = 256,
  parameter int LOSS_ERRS  = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] rx_i,
  input  logic [DATA_WIDTH-1:0] rx_q,
  input  logic                  clr_cnt,
  output logic                  locked,
  output logic                  err_valid,
  output logic [1:0]            err_bits,
  output logic [CNT_WIDTH-1:0]  bit_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int LOCK_W = $clog2(LOCK_SYMS + 1);
  localparam int WIN_W  = (WIN_SYMS > 1) ? $clog2(WIN_SYMS) : 1;
  // The window accumulator never holds LOSS_ERRS or more, so the sum with one
  // symbol's popcount stays below LOSS_ERRS + 2.
  localparam int WERR_W = $clog2(LOSS_ERRS + 2) + 1;

  // Stage 1: slicer
  logic r_b_i;
  logic r_b_q;
  logic r_v1;

  // Stage 2: LFSR, FSM, window tracking, registered outputs
  logic [8:0]           r_lfsr;
  state_e               r_state;
  logic [LOCK_W-1:0]    r_lock_cnt;
  logic [WIN_W-1:0]     r_win_cnt;
  logic [WERR_W-1:0]    r_win_err;
  logic                 r_locked;
  logic                 r_err_valid;
  logic [1:0]           r_err_bits;
  logic [CNT_WIDTH-1:0] r_bit_cnt;
  logic [CNT_WIDTH-1:0] r_err_cnt;

  logic [8:0]           w_lfsr_next;
  logic                 w_p_i;
  logic                 w_p_q;
  logic [1:0]           w_err;
  logic [1:0]           w_pop;
  logic [LOCK_W-1:0]    w_lock_inc;
  logic [WERR_W-1:0]    w_win_sum;
  logic [CNT_WIDTH:0]   w_bit_sum;
  logic [CNT_WIDTH:0]   w_err_sum;
  logic                 w_count_en;
  logic                 w_unused_lsbs;

  // Only the sign bit carries information for a hard decision.
  assign w_unused_lsbs = ^{rx_i[DATA_WIDTH-2:0], rx_q[DATA_WIDTH-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_i <= 1'b0;
      r_b_q <= 1'b0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= en;
      if (en) begin
        r_b_i <= slice_bit(rx_i[DATA_WIDTH-1]);
        r_b_q <= slice_bit(rx_q[DATA_WIDTH-1]);
      end
    end
  end

  prbs9_step2 u_step (
    .lfsr_in  (r_lfsr),
    .mode     (r_state),
    .b_i      (r_b_i),
    .b_q      (r_b_q),
    .lfsr_out (w_lfsr_next),
    .p_i      (w_p_i),
    .p_q      (w_p_q)
  );

  assign w_err      = {r_b_i ^ w_p_i, r_b_q ^ w_p_q};
  assign w_pop      = popcount2(w_err);
  assign w_lock_inc = r_lock_cnt + LOCK_W'(1);
  assign w_win_sum  = r_win_err + WERR_W'(w_pop);

  // Lock FSM. The symbol that causes a transition is handled entirely under
  // the state it arrived in (LFSR mode, counting), the new state applies from
  // the next symbol on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= PRBS_SEED;
      r_state     <= STATE_SEARCH;
      r_lock_cnt  <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_bits  <= 2'b00;
    end else begin
      r_err_valid <= r_v1;
      if (r_v1) begin
        r_err_bits <= w_err;
        r_lfsr     <= w_lfsr_next;
        case (r_state)
          STATE_SEARCH: begin
            if (w_err != 2'b00) begin
              r_lock_cnt <= '0;
            end else if (r_lfsr != 9'd0) begin
              // An all-zero register predicts zeros forever and would match an
              // all-zero (dead) input, so it never earns lock credit.
              if (w_lock_inc == LOCK_W'(LOCK_SYMS)) begin
                r_state    <= STATE_LOCKED;
                r_locked   <= 1'b1;
                r_lock_cnt <= '0;
                r_win_cnt  <= '0;
                r_win_err  <= '0;
              end else begin
                r_lock_cnt <= w_lock_inc;
              end
            end
          end
          STATE_LOCKED: begin
            if (w_win_sum >= WERR_W'(LOSS_ERRS)) begin
              r_state    <= STATE_SEARCH;
              r_locked   <= 1'b0;
              r_lock_cnt <= '0;
              r_win_cnt  <= '0;
              r_win_err  <= '0;
            end else if (r_win_cnt == WIN_W'(WIN_SYMS - 1)) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
              r_win_err <= w_win_sum;
            end
          end
          default: begin
            r_state  <= STATE_SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating statistics; clear has priority over a same-cycle increment.
  assign w_count_en = r_v1 && (r_state == STATE_LOCKED);
  assign w_bit_sum  = {1'b0, r_bit_cnt} + (CNT_WIDTH + 1)'(2);
  assign w_err_sum  = {1'b0, r_err_cnt} + (CNT_WIDTH + 1)'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_count_en) begin
      r_bit_cnt <= w_bit_sum[CNT_WIDTH] ? '1 : w_bit_sum[CNT_WIDTH-1:0];
      r_err_cnt <= w_err_sum[CNT_WIDTH] ? '1 : w_err_sum[CNT_WIDTH-1:0];
    end
  end

  assign locked    = r_locked;
  assign err_valid = r_err_valid;
  assign err_bits  = r_err_bits;
  assign bit_cnt   = r_bit_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rx_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_rx_prbs_checker
// Directed bench for rx_prbs_checker. A reference PRBS9 transmitter produces
// the symbol stream (+/-16'h4000); two checker instances (32-bit and 4-bit
// counters) see identical stimulus.
// -----------------------------------------------------------------------------
module tb_rx_prbs_checker;

  localparam logic [15:0] POS = 16'h4000;
  localparam logic [15:0] NEG = 16'hC000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr_cnt;
  logic [15:0] rx_i;
  logic [15:0] rx_q;

  logic        locked, err_valid;
  logic [1:0]  err_bits;
  logic [31:0] bit_cnt, err_cnt;
  logic        locked4, err_valid4;
  logic [1:0]  err_bits4;
  logic [3:0]  bit_cnt4, err_cnt4;

  int checks = 0;
  int errors = 0;
  logic [8:0] tx_s;

  always #5 clk = ~clk;

  rx_prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_i(rx_i), .rx_q(rx_q), .clr_cnt(clr_cnt),
    .locked(locked), .err_valid(err_valid), .err_bits(err_bits),
    .bit_cnt(bit_cnt), .err_cnt(err_cnt)
  );

  rx_prbs_checker #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_i(rx_i), .rx_q(rx_q), .clr_cnt(clr_cnt),
    .locked(locked4), .err_valid(err_valid4), .err_bits(err_bits4),
    .bit_cnt(bit_cnt4), .err_cnt(err_cnt4)
  );

  // One valid symbol, then step past the sampling edge.
  task automatic drive_sym(input logic bi, input logic bq);
    en   = 1'b1;
    rx_i = bi ? NEG : POS;
    rx_q = bq ? NEG : POS;
    @(posedge clk); #1;
    en   = 1'b0;
  endtask

  // Next transmitter symbol (I first, then Q), optionally with bits flipped.
  task automatic tx_sym(input logic inv_i, input logic inv_q);
    logic bi, bq;
    bi   = tx_s[8] ^ tx_s[4];
    tx_s = {tx_s[7:0], bi};
    bq   = tx_s[8] ^ tx_s[4];
    tx_s = {tx_s[7:0], bq};
    drive_sym(bi ^ inv_i, bq ^ inv_q);
  endtask

  // Idle cycle with junk on the sample inputs.
  task automatic bubble();
    en   = 1'b0;
    rx_i = 16'($urandom);
    rx_q = 16'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [8:0] seed);
    rst_n = 1'b0; en = 1'b0; clr_cnt = 1'b0; rx_i = '0; rx_q = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tx_s = seed;
  endtask

  task automatic lock_clean();
    repeat (16) tx_sym(1'b0, 1'b0);
    bubble();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr_cnt = 1'b0; rx_i = '0; rx_q = '0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({locked, err_valid, err_bits, bit_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: locked=%b err_valid=%b err_bits=%b bit_cnt=%0d err_cnt=%0d, required all 0",
               locked, err_valid, err_bits, bit_cnt, err_cnt);
    end
    checks++;
    if ({locked4, err_valid4, err_bits4, bit_cnt4, err_cnt4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_w4: got nonzero output, required all 0");
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bubble();
      checks++;
      if (err_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_valid: err_valid=%b required 0 (cycle %0d)", err_valid, k);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_lock();
    do_reset(9'h1FF);
    repeat (15) tx_sym(1'b0, 1'b0);
    bubble();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: locked=%b after 15 symbols, required 0", locked);
    end
    tx_sym(1'b0, 1'b0);
    bubble();
    checks++;
    if (locked !== 1'b1 || bit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL lock_at_16: locked=%b bit_cnt=%0d, required 1 and 0", locked, bit_cnt);
    end
    repeat (984) tx_sym(1'b0, 1'b0);
    bubble();
    checks++;
    if (bit_cnt !== 32'd1968 || err_cnt !== 32'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_1000: bit_cnt=%0d err_cnt=%0d locked=%b, required 1968 0 1", bit_cnt, err_cnt, locked);
    end
    $display("test_clean_lock done");
  endtask

  task automatic test_sync();
    int n;
    do_reset(9'h0A5);
    n = 0;
    while (locked !== 1'b1 && n < 40) begin
      tx_sym(1'b0, 1'b0);
      n++;
    end
    // locked reflects the previous symbol, so lock was declared on symbol n-1.
    checks++;
    if (locked !== 1'b1 || (n - 1) > 21) begin
      errors++;
      $display("FAIL sync_lock: locked=%b lock_symbol=%0d, required 1 at or before 21", locked, n - 1);
    end
    $display("test_sync done");
  endtask

  task automatic test_injected();
    rst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || err_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: locked=%b err_valid=%b, required 0 0", locked, err_valid);
    end
    do_reset(9'h1FF);
    lock_clean();
    repeat (10) tx_sym(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tx_sym(1'b1, 1'b0);
      bubble();
      checks++;
      if (err_valid !== 1'b1 || err_bits !== 2'b10) begin
        errors++;
        $display("FAIL inj_bits: err_valid=%b err_bits=%b, required 1 10 (inj %0d)", err_valid, err_bits, k);
      end
      tx_sym(1'b0, 1'b0);
      bubble();
      checks++;
      if (err_valid !== 1'b1 || err_bits !== 2'b00) begin
        errors++;
        $display("FAIL clean_bits: err_valid=%b err_bits=%b, required 1 00 (after %0d)", err_valid, err_bits, k);
      end
    end
    checks++;
    if (err_cnt !== 32'd3 || bit_cnt !== 32'd32 || locked !== 1'b1) begin
      errors++;
      $display("FAIL inj_totals: err_cnt=%0d bit_cnt=%0d locked=%b, required 3 32 1", err_cnt, bit_cnt, locked);
    end
    $display("test_injected done");
  endtask

  task automatic test_loss();
    do_reset(9'h1FF);
    lock_clean();
    repeat (15) tx_sym(1'b1, 1'b1);
    bubble();
    checks++;
    if (locked !== 1'b1 || err_cnt !== 32'd30) begin
      errors++;
      $display("FAIL loss_15: locked=%b err_cnt=%0d, required 1 30", locked, err_cnt);
    end
    tx_sym(1'b1, 1'b1);
    bubble();
    checks++;
    if (locked !== 1'b0 || err_cnt !== 32'd32 || bit_cnt !== 32'd32) begin
      errors++;
      $display("FAIL loss_16: locked=%b err_cnt=%0d bit_cnt=%0d, required 0 32 32", locked, err_cnt, bit_cnt);
    end
    repeat (15) tx_sym(1'b0, 1'b0);
    bubble();
    checks++;
    if (locked !== 1'b0 || err_cnt !== 32'd32) begin
      errors++;
      $display("FAIL relock_early: locked=%b err_cnt=%0d, required 0 32", locked, err_cnt);
    end
    tx_sym(1'b0, 1'b0);
    bubble();
    checks++;
    if (locked !== 1'b1 || err_cnt !== 32'd32 || bit_cnt !== 32'd32) begin
      errors++;
      $display("FAIL relock: locked=%b err_cnt=%0d bit_cnt=%0d, required 1 32 32", locked, err_cnt, bit_cnt);
    end
    clr_cnt = 1'b1;
    bubble();
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt !== 32'd0 || bit_cnt !== 32'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clr_after_loss: err_cnt=%0d bit_cnt=%0d locked=%b, required 0 0 1", err_cnt, bit_cnt, locked);
    end
    $display("test_loss done");
  endtask

  task automatic test_window();
    // Symbol 256 still belongs to the first window: 30 + 2 errors -> loss.
    do_reset(9'h1FF);
    lock_clean();
    repeat (15) tx_sym(1'b1, 1'b1);
    repeat (240) tx_sym(1'b0, 1'b0);
    tx_sym(1'b1, 1'b1);
    bubble();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL window_last_sym: locked=%b, required 0", locked);
    end
    // Symbol 257 opens a fresh window: only 2 errors there -> lock kept.
    do_reset(9'h1FF);
    lock_clean();
    repeat (15) tx_sym(1'b1, 1'b1);
    repeat (241) tx_sym(1'b0, 1'b0);
    tx_sym(1'b1, 1'b1);
    bubble();
    checks++;
    if (locked !== 1'b1 || err_cnt !== 32'd32) begin
      errors++;
      $display("FAIL window_new: locked=%b err_cnt=%0d, required 1 32", locked, err_cnt);
    end
    $display("test_window done");
  endtask

  task automatic test_gaps_clear();
    int n;
    do_reset(9'h1FF);
    lock_clean();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        tx_sym(1'b0, 1'b0);
        n++;
      end else begin
        bubble();
      end
    end
    bubble();
    checks++;
    if (bit_cnt !== 32'(2 * n) || err_cnt !== 32'd0) begin
      errors++;
      $display("FAIL gaps_count: bit_cnt=%0d err_cnt=%0d, required %0d 0", bit_cnt, err_cnt, 2 * n);
    end
    tx_sym(1'b1, 1'b0);
    clr_cnt = 1'b1;
    bubble();
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt !== 32'd0 || bit_cnt !== 32'd0 || err_valid !== 1'b1 || err_bits !== 2'b10) begin
      errors++;
      $display("FAIL clr_wins: err_cnt=%0d bit_cnt=%0d err_valid=%b err_bits=%b, required 0 0 1 10",
               err_cnt, bit_cnt, err_valid, err_bits);
    end
    tx_sym(1'b1, 1'b0);
    bubble();
    checks++;
    if (err_cnt !== 32'd1 || bit_cnt !== 32'd2) begin
      errors++;
      $display("FAIL post_clr: err_cnt=%0d bit_cnt=%0d, required 1 2", err_cnt, bit_cnt);
    end
    $display("test_gaps_clear done");
  endtask

  task automatic test_degenerate();
    do_reset(9'h1FF);
    for (int k = 0; k < 100; k++) begin
      en = 1'b1; rx_i = '0; rx_q = '0;
      @(posedge clk); #1;
    end
    bubble();
    checks++;
    if (locked !== 1'b0 || locked4 !== 1'b0 || bit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL zero_stream: locked=%b locked4=%b bit_cnt=%0d, required 0 0 0", locked, locked4, bit_cnt);
    end
    $display("test_degenerate done");
  endtask

  task automatic test_saturation();
    do_reset(9'h1FF);
    lock_clean();
    repeat (7) tx_sym(1'b0, 1'b0);
    bubble();
    checks++;
    if (bit_cnt4 !== 4'd14 || bit_cnt !== 32'd14) begin
      errors++;
      $display("FAIL sat_pre: bit_cnt4=%0d bit_cnt=%0d, required 14 14", bit_cnt4, bit_cnt);
    end
    tx_sym(1'b0, 1'b0);
    bubble();
    checks++;
    if (bit_cnt4 !== 4'hF) begin
      errors++;
      $display("FAIL sat_edge: bit_cnt4=%0h required f", bit_cnt4);
    end
    repeat (3) tx_sym(1'b0, 1'b0);
    bubble();
    checks++;
    if (bit_cnt4 !== 4'hF || bit_cnt !== 32'd22) begin
      errors++;
      $display("FAIL sat_hold: bit_cnt4=%0h bit_cnt=%0d, required f 22", bit_cnt4, bit_cnt);
    end
    repeat (16) tx_sym(1'b1, 1'b0);
    bubble();
    checks++;
    if (err_cnt4 !== 4'hF || err_cnt !== 32'd16 || locked4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_err: err_cnt4=%0h err_cnt=%0d locked4=%b, required f 16 1", err_cnt4, err_cnt, locked4);
    end
    $display("test_saturation done");
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_cnt = 1'b0; rx_i = '0; rx_q = '0; tx_s = 9'h1FF;
    test_reset();
    test_clean_lock();
    test_sync();
    test_injected();
    test_loss();
    test_window();
    test_gaps_clear();
    test_degenerate();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
